fp_mul_seq: RTL and testbench
=============================

// Module: fp_mul_seq
// PURPOSE
//  Sequential IEEE-754 single-precision multiplier: the inverse operator of the FP32 divider.
//  Also used to check divider results (q*B ~= A) in self-checking benches.
//  Iterative shift-add mantissa multiply under a start/busy/done handshake.
//  Round-to-nearest-even; denormals flushed to zero.
// PARAMETERS
//  RADIX_BITS  1             multiplier bits consumed per MUL cycle; legal 1,2,3,4,6,8
//  QNAN        32'h7FC0_0000 canonical quiet NaN returned for every NaN result
// PORTS
//  clk     in   1   rising-edge clock
//  rst_n   in   1   asynchronous, active-low reset
//  start   in   1   request; sampled only in IDLE
//  a       in   32  multiplicand, FP32; captured on accepted start
//  b       in   32  multiplier, FP32; captured on accepted start
//  busy    out  1   high from cycle after accepted start until done cycle inclusive
//  done    out  1   one-cycle pulse; result/flags valid from this cycle
//  result  out  32  FP32 product; held until next accepted start
//  flags   out  4   {invalid, overflow, underflow, inexact}; same timing as result
// BEHAVIOUR
//  Reset: async on rst_n low -> state IDLE; busy=0, done=0, result=0, flags=0.
//   Reset mid-operation aborts, no done pulse. All outputs stay 0 until first done.
//  FSM: IDLE -> UNPACK -> MUL -> NORM -> ROUND -> DONE -> IDLE.
//   Special-case path: UNPACK -> DONE.
//  IDLE: start=1 captures a,b -> UNPACK. start while busy is ignored; not queued.
//  UNPACK: split sign/exp/mant; exp==0 -> operand is zero (flush, sign kept).
//   Append hidden 1 to normal mantissas (24b).
//   Special cases -> DONE next cycle:
//   - any NaN, or 0*inf: result=QNAN, invalid=1.
//   - inf*finite-nonzero: {s,8'hFF,23'h0}.
//   - zero*finite: {s,31'h0}.
//   s = sa^sb always (except NaN).
//  MUL: 48b product; consume RADIX_BITS of mant_b per cycle, LSB first.
//   Runs 24/RADIX_BITS cycles; cycle counter, no early exit.
//  NORM: exp = ea+eb-127 (10b signed). If prod[47] -> exp+1, use prod[47:24].
//   Otherwise use prod[46:23]. Guard/round/sticky come from remaining low bits.
//  ROUND: RNE, increment if G & (R|S|lsb). Mantissa carry-out -> exp+1, mantissa=0.
//   inexact = G|R|S.
//   - exp>=255: {s,8'hFF,23'h0}, overflow=1, inexact=1.
//   - exp<=0: {s,31'h0}, underflow=1, inexact=1 (no denormal output).
//  DONE: result/flags registered, done=1 one cycle, busy drops next cycle.
//   start is accepted again in the following (IDLE) cycle.
//  Latency, start sampled at cycle 0:
//   - normal path: done at cycle 4+24/RADIX_BITS (28 for RADIX_BITS=1).
//   - special path: done at cycle 2.
//  Throughput: one operation per latency+1 cycles.
// TESTING
//  RADIX_BITS=1 unless stated.
//  a=0x40000000, b=0x40400000 (2*3) -> result 0x40C00000, flags 0, done exactly at cycle 28.
//  a=0xC0000000, b=0x40400000 -> 0xC0C00000.
//   a=b=0x3F800001 -> 0x3F800002, flags 4'b0001.
//  a=0x00000000, b=0x7F800000 -> 0x7FC00000, flags 4'b1000, done at cycle 2.
//   a=0x7FC00001, b=1.0 -> 0x7FC00000.
//  a=0x7F7FFFFF, b=0x40000000 -> 0x7F800000, flags 4'b0101.
//   a=0x00800000, b=0x3F000000 -> 0x00000000, flags 4'b0011.
//  Pulse start again at cycle 5 -> ignored, single done.
//   rst_n low at cycle 10 -> busy=0, no done.
//   Next op completes correctly.
//  500 random normal pairs per RADIX_BITS in {1,4,8}: bit-exact vs shortreal a*b.
//   Cases with denormal result are excluded.

Source files
------------

// File: rtl/fp_mul_seq.sv
// Sequential FP32 multiplier: iterative shift-add mantissa product with RNE rounding.
// Denormal inputs are treated as signed zero; results below the normal range flush to zero.
module fp_mul_seq #(
  parameter int unsigned RADIX_BITS = 1,
  parameter logic [31:0] QNAN       = 32'h7FC0_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [3:0]  flags
);

  localparam int unsigned MUL_CYCLES = 24 / RADIX_BITS;
  localparam int unsigned CW         = $clog2(MUL_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_UNPACK, S_MUL, S_NORM, S_ROUND, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic        [31:0] a_q, a_d, b_q, b_d;
  logic               sign_q, sign_d;
  logic signed [9:0]  exp_q, exp_d;
  logic        [47:0] mcand_q, mcand_d;
  logic        [23:0] mplier_q, mplier_d;
  logic        [47:0] prod_q, prod_d;
  logic      [CW-1:0] cnt_q, cnt_d;
  logic        [23:0] mant_q, mant_d;
  logic        [2:0]  grs_q, grs_d;
  logic        [31:0] result_q, result_d;
  logic        [3:0]  flags_q, flags_d;

  logic [7:0]            ea, eb;
  logic                  a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, s_ab;
  logic [RADIX_BITS-1:0] digit;
  logic [47:0]           pp;
  logic                  rnd_up, inexact;
  logic [24:0]           sum;
  logic signed [9:0]     exp_r;

  always_comb begin
    ea     = a_q[30:23];
    eb     = b_q[30:23];
    a_zero = (ea == '0);
    b_zero = (eb == '0);
    a_inf  = (ea == '1) && (a_q[22:0] == '0);
    b_inf  = (eb == '1) && (b_q[22:0] == '0);
    a_nan  = (ea == '1) && (a_q[22:0] != '0);
    b_nan  = (eb == '1) && (b_q[22:0] != '0);
    s_ab   = a_q[31] ^ b_q[31];
  end

  // One radix digit of the multiplier times the pre-shifted multiplicand.
  always_comb begin
    digit = mplier_q[RADIX_BITS-1:0];
    pp    = mcand_q * {{(48-RADIX_BITS){1'b0}}, digit};
  end

  always_comb begin
    rnd_up  = grs_q[2] & (grs_q[1] | grs_q[0] | mant_q[0]);
    sum     = {1'b0, mant_q} + {24'h0, rnd_up};
    exp_r   = sum[24] ? (exp_q + 10'sd1) : exp_q;
    inexact = |grs_q;
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    mant_d   = mant_q;
    grs_d    = grs_q;
    result_d = result_q;
    flags_d  = flags_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          state_d = S_UNPACK;
        end
      end
      S_UNPACK: begin
        sign_d   = s_ab;
        exp_d    = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
        mcand_d  = {24'h0, 1'b1, a_q[22:0]};
        mplier_d = {1'b1, b_q[22:0]};
        prod_d   = '0;
        cnt_d    = '0;
        state_d  = S_MUL;
        if (a_nan || b_nan || (a_zero && b_inf) || (a_inf && b_zero)) begin
          result_d = QNAN;
          flags_d  = 4'b1000;
          state_d  = S_DONE;
        end else if (a_inf || b_inf) begin
          result_d = {s_ab, 8'hFF, 23'h0};
          flags_d  = '0;
          state_d  = S_DONE;
        end else if (a_zero || b_zero) begin
          result_d = {s_ab, 31'h0};
          flags_d  = '0;
          state_d  = S_DONE;
        end
      end
      S_MUL: begin
        prod_d   = prod_q + pp;
        mcand_d  = mcand_q << RADIX_BITS;
        mplier_d = mplier_q >> RADIX_BITS;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(MUL_CYCLES - 1)) state_d = S_NORM;
      end
      S_NORM: begin
        if (prod_q[47]) begin
          exp_d  = exp_q + 10'sd1;
          mant_d = prod_q[47:24];
          grs_d  = {prod_q[23], prod_q[22], |prod_q[21:0]};
        end else begin
          mant_d = prod_q[46:23];
          grs_d  = {prod_q[22], prod_q[21], |prod_q[20:0]};
        end
        state_d = S_ROUND;
      end
      S_ROUND: begin
        // Range checks use the post-rounding exponent so a carry into 255 overflows.
        if (exp_r >= 10'sd255) begin
          result_d = {sign_q, 8'hFF, 23'h0};
          flags_d  = 4'b0101;
        end else if (exp_r <= 10'sd0) begin
          result_d = {sign_q, 31'h0};
          flags_d  = 4'b0011;
        end else begin
          result_d = {sign_q, exp_r[7:0], sum[22:0]};
          flags_d  = {3'b000, inexact};
        end
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      mant_q   <= '0;
      grs_q    <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      mant_q   <= mant_d;
      grs_q    <= grs_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign result = result_q;
  assign flags  = flags_q;

endmodule

// File: tb/tb_fp_mul_seq.sv
// Bench for fp_mul_seq: three radix variants share stimulus and are checked every cycle
// against an integer-arithmetic FP32 multiply model.
module tb_fp_mul_seq;

  localparam int MAXC = 29;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] a, b;
  logic        busy_w [3];
  logic        done_w [3];
  logic [31:0] res_w  [3];
  logic [3:0]  flg_w  [3];

  int          errors = 0;
  int          checks = 0;
  int          cyc    = 0;
  bit          active = 1'b0;
  int          rst_at = 0;
  int          exp_lat [3];
  int          rb      [3] = '{1, 4, 8};
  logic [31:0] exp_res;
  logic [3:0]  exp_flg;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    fp_mul_seq #(
      .RADIX_BITS((g == 0) ? 1 : (g == 1) ? 4 : 8),
      .QNAN      (32'h7FC0_0000)
    ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .busy  (busy_w[g]),
      .done  (done_w[g]),
      .result(res_w[g]),
      .flags (flg_w[g])
    );
  end

  task automatic check(input string nm, input logic [35:0] act, input logic [35:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference multiply: exact 48-bit product, round-half-even by remainder comparison.
  task automatic model(input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] r, output logic [3:0] f, output bit sp);
    logic s;
    int   ex, ey, e, sh;
    bit   nx, ny, ix, iy, zx, zy, inx;
    longint unsigned p, m, rem, half;
    s  = x[31] ^ y[31];
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    nx = (ex == 255) && (x[22:0] != 0);
    ny = (ey == 255) && (y[22:0] != 0);
    ix = (ex == 255) && (x[22:0] == 0);
    iy = (ey == 255) && (y[22:0] == 0);
    zx = (ex == 0);
    zy = (ey == 0);
    sp = 1'b1;
    f  = 4'b0000;
    r  = 32'h0;
    if (nx || ny || (zx && iy) || (ix && zy)) begin
      r = 32'h7FC0_0000;
      f = 4'b1000;
    end else if (ix || iy) begin
      r = {s, 8'hFF, 23'h0};
    end else if (zx || zy) begin
      r = {s, 31'h0};
    end else begin
      sp = 1'b0;
      p  = longint'({1'b1, x[22:0]}) * longint'({1'b1, y[22:0]});
      e  = ex + ey - 127;
      if (p >= 64'h8000_0000_0000) begin
        e++;
        sh = 24;
      end else begin
        sh = 23;
      end
      m    = p >> sh;
      rem  = p - (m << sh);
      half = 64'd1 << (sh - 1);
      inx  = (rem != 0);
      if (rem > half || (rem == half && m[0])) m++;
      if (m == (64'd1 << 24)) begin
        m = m >> 1;
        e++;
      end
      if (e >= 255) begin
        r = {s, 8'hFF, 23'h0};
        f = 4'b0101;
      end else if (e <= 0) begin
        r = {s, 31'h0};
        f = 4'b0011;
      end else begin
        r = {s, e[7:0], m[22:0]};
        f = {3'b000, inx};
      end
    end
  endtask

  always @(negedge clk) begin
    if (active && cyc >= 1) begin
      for (int g = 0; g < 3; g++) begin
        if (rst_at != 0 && cyc >= rst_at) begin
          check($sformatf("abort_r%0d", rb[g]),
                {busy_w[g], done_w[g], flg_w[g], res_w[g]}, {2'b00, 4'h0, 32'h0});
        end else begin
          check($sformatf("busy_r%0d", rb[g]), 36'(busy_w[g]), 36'(cyc <= exp_lat[g]));
          check($sformatf("done_r%0d", rb[g]), 36'(done_w[g]), 36'(cyc == exp_lat[g]));
          if (cyc >= exp_lat[g])
            check($sformatf("result_r%0d", rb[g]), {flg_w[g], res_w[g]}, {exp_flg, exp_res});
        end
      end
    end
  end

  task automatic do_op(input logic [31:0] x, input logic [31:0] y,
                       input int pulse_at, input int rst_cyc);
    logic [31:0] r;
    logic [3:0]  f;
    bit          sp;
    model(x, y, r, f, sp);
    @(negedge clk);
    exp_res = r;
    exp_flg = f;
    for (int g = 0; g < 3; g++) exp_lat[g] = sp ? 2 : 4 + 24 / rb[g];
    rst_at = rst_cyc;
    a      = x;
    b      = y;
    start  = 1'b1;
    cyc    = 0;
    active = 1'b1;
    for (int c = 1; c <= MAXC; c++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      cyc   = c;
      if (c == pulse_at) begin
        a     = 32'h3F80_0000;
        b     = 32'h3F80_0000;
        start = 1'b1;
      end
      if (rst_cyc != 0 && c == rst_cyc)     rst_n = 1'b0;
      if (rst_cyc != 0 && c == rst_cyc + 2) rst_n = 1'b1;
    end
    @(negedge clk);
    active = 1'b0;
    rst_at = 0;
  endtask

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] r;
    logic [3:0]  f;
  } vec_t;

  vec_t vecs [7] = '{
    '{32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 4'b0000},
    '{32'hC000_0000, 32'h4040_0000, 32'hC0C0_0000, 4'b0000},
    '{32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002, 4'b0001},
    '{32'h0000_0000, 32'h7F80_0000, 32'h7FC0_0000, 4'b1000},
    '{32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 4'b1000},
    '{32'h7F7F_FFFF, 32'h4000_0000, 32'h7F80_0000, 4'b0101},
    '{32'h0080_0000, 32'h3F00_0000, 32'h0000_0000, 4'b0011}
  };

  initial begin
    logic [31:0] r, x, y;
    logic [3:0]  f;
    bit          sp;
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    for (int g = 0; g < 3; g++)
      check($sformatf("reset_r%0d", rb[g]),
            {busy_w[g], done_w[g], flg_w[g], res_w[g]}, {2'b00, 4'h0, 32'h0});
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      model(vecs[i].x, vecs[i].y, r, f, sp);
      check($sformatf("model_pin%0d", i), {f, r}, {vecs[i].f, vecs[i].r});
      do_op(vecs[i].x, vecs[i].y, 0, 0);
    end

    do_op(32'h4000_0000, 32'h4040_0000, 5, 0);
    do_op(32'h4000_0000, 32'h4040_0000, 0, 10);
    do_op(32'hC000_0000, 32'h4040_0000, 0, 0);

    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        x = $urandom;
        y = $urandom;
      end else begin
        x = {1'($urandom), 8'($urandom_range(64, 190)), 23'($urandom)};
        y = {1'($urandom), 8'($urandom_range(64, 190)), 23'($urandom)};
      end
      do_op(x, y, 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
